display_scanner: RTL and testbench
==================================

// Module: display_scanner
// PURPOSE
//   Responder end of the display-slot interface. Sweeps display_number over a slot range.
//   Captures each valid {display_name, display_value} response.
//   Emits each valid slot as an ASCII line on a byte stream with valid/ready handshake
//   (UART TX / debug log), e.g. "M_OP1=0000002A\r\n".
//   Sits beside any top that implements the display_number -> display_valid/name/value case table.
// PARAMETERS
//   FIRST_NUM  6'd1   first slot requested per sweep
//   LAST_NUM   6'd44  last slot requested per sweep; FIRST_NUM <= LAST_NUM required
// PORTS
//   clk             in   1   system clock
//   resetn          in   1   asynchronous, active-low reset
//   scan_start      in   1   start one sweep; sampled only in IDLE
//   display_number  out  6   slot being requested
//   display_valid   in   1   slot populated (registered by responder: 1-cycle latency)
//   display_name    in   40  5 ASCII chars, [39:32] first
//   display_value   in   32  slot value
//   tx_data         out  8   ASCII byte
//   tx_valid        out  1   tx_data valid
//   tx_ready        in   1   sink accepts; transfer when tx_valid && tx_ready
//   scan_busy       out  1   high in every state except IDLE
//   scan_done       out  1   one-cycle pulse at sweep end
// BEHAVIOUR
//   Reset values (async, immediate): display_number=6'd0, tx_data=8'h00, tx_valid=0,
//     scan_busy=0, scan_done=0, state=IDLE, line buffer cleared. Reset mid-line aborts the line.
//   FSM states: IDLE, WAIT, CAPTURE, SEND.
//   IDLE: scan_start=1 -> display_number<=FIRST_NUM, go WAIT. scan_start outside IDLE ignored.
//   WAIT: one cycle; lets responder register its reply -> CAPTURE.
//   CAPTURE: sample display_valid/name/value.
//     - Valid: latch name and value, byte index<=0, go SEND.
//     - Invalid, number<LAST_NUM: number+1, go WAIT.
//     - Invalid, number==LAST_NUM: scan_done<=1 for one cycle, go IDLE.
//     - Empty slot costs exactly 2 cycles.
//   SEND: line is 16 bytes: name[39:32]..name[7:0], '=', 8 hex nibbles MSB first, 8'h0D, 8'h0A.
//     - Name byte 8'h00 is sent as 8'h20 (space). Other name bytes pass unchanged.
//     - Hex digits are 0-9 / A-F (uppercase).
//     - tx_valid is held with tx_data stable until a transfer occurs; no bubble between bytes
//       when tx_ready stays high.
//     - The transfer of the last byte advances the sweep: next slot (go WAIT), or scan_done
//       pulse and IDLE if number==LAST_NUM.
//   Captured name/value are frozen for the whole line, even if the responder changes mid-line.
//   display_number holds its last value in IDLE after a sweep.
//   LAST_NUM=63 must not wrap: the comparison is on equality, so it never reaches 0.
// CONFIGURATION
//   SCAN_INDEX_EN defined:
//     - Each line is prefixed with display_number as 2 decimal ASCII digits and ':'.
//     - Example: "41:M_OP1=0000002A\r\n". Line is 19 bytes.
//   SCAN_INDEX_EN undefined: no prefix. Line is 16 bytes.
// TESTING
//   1 Slot 41 returns "M_OP1"/32'h0000_002A; all others invalid; tx_ready=1; pulse scan_start
//     -> exactly "M_OP1=0000002A\r\n" (16 bytes), then a single scan_done pulse.
//   2 All slots invalid, FIRST=1, LAST=44; pulse scan_start -> no tx_valid.
//     scan_done high exactly 88 cycles after the start edge; scan_busy high in between.
//   3 Slot 43 returns "PRO_H"/32'hDEAD_BEEF; tx_ready low for 10 cycles at byte 7
//     -> tx_data stays 'D' with tx_valid=1; stream is "PRO_H=DEADBEEF\r\n" with no drop or duplicate.
//   4 Slot 42 returns name 40'h00_00_00_41_42, value 0 -> "   AB=00000000\r\n".
//     Re-pulsing scan_start mid-sweep does not restart the sweep.
//   5 Deassert resetn while the 6th byte is pending -> tx_valid, scan_busy and scan_done drop
//     immediately; after release a new scan_start sweeps from FIRST_NUM.
//   6 With SCAN_INDEX_EN, scenario 1 -> "41:M_OP1=0000002A\r\n" (19 bytes).

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: sweeps display_number over [FIRST_NUM, LAST_NUM], captures each
// populated slot's {display_name, display_value} and streams it as one ASCII line,
// e.g. "M_OP1=0000002A\r\n", over a valid/ready byte interface.
// Optional feature: define SCAN_INDEX_EN to prefix each line with the slot number
// as two decimal digits and ':' (e.g. "41:M_OP1=0000002A\r\n").
module display_scanner #(
    parameter logic [5:0] FIRST_NUM = 6'd1,
    parameter logic [5:0] LAST_NUM  = 6'd44
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        scan_start,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        scan_busy,
    output logic        scan_done
);

`ifdef SCAN_INDEX_EN
    localparam int PREFIX_LEN = 3;
`else
    localparam int PREFIX_LEN = 0;
`endif
    localparam logic [4:0] LAST_IDX = 5'(PREFIX_LEN + 15);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_SEND} state_e;

    state_e      state_q, state_d;
    logic [5:0]  number_q, number_d;
    logic [4:0]  idx_q, idx_d;
    logic [39:0] name_q, name_d;
    logic [31:0] value_q, value_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [39:0] src_name;
    logic [31:0] src_value;
    logic [4:0]  src_idx;
    logic [7:0]  next_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // A NUL name character prints as a space so short names stay aligned.
    function automatic logic [7:0] name_char(input logic [7:0] c);
        return (c == 8'h00) ? 8'h20 : c;
    endfunction

    // Byte at position pos of the unprefixed line: 5 name chars, '=', 8 hex digits, CR, LF.
    function automatic logic [7:0] body_byte(input logic [39:0] name,
                                             input logic [31:0] value,
                                             input logic [4:0]  pos);
        logic [7:0] b;
        case (pos)
            5'd0:    b = name_char(name[39:32]);
            5'd1:    b = name_char(name[31:24]);
            5'd2:    b = name_char(name[23:16]);
            5'd3:    b = name_char(name[15:8]);
            5'd4:    b = name_char(name[7:0]);
            5'd5:    b = 8'h3D;
            5'd6:    b = hex_char(value[31:28]);
            5'd7:    b = hex_char(value[27:24]);
            5'd8:    b = hex_char(value[23:20]);
            5'd9:    b = hex_char(value[19:16]);
            5'd10:   b = hex_char(value[15:12]);
            5'd11:   b = hex_char(value[11:8]);
            5'd12:   b = hex_char(value[7:4]);
            5'd13:   b = hex_char(value[3:0]);
            5'd14:   b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Select the byte to load next: byte 0 straight from the responder while capturing,
    // otherwise the following byte of the frozen line.
    always_comb begin
        if (state_q == S_CAPTURE) begin
            src_name  = display_name;
            src_value = display_value;
            src_idx   = 5'd0;
        end else begin
            src_name  = name_q;
            src_value = value_q;
            src_idx   = idx_q + 5'd1;
        end
`ifdef SCAN_INDEX_EN
        if (src_idx == 5'd0) begin
            next_byte = 8'h30 + {2'b00, number_q / 6'd10};
        end else if (src_idx == 5'd1) begin
            next_byte = 8'h30 + {2'b00, number_q % 6'd10};
        end else if (src_idx == 5'd2) begin
            next_byte = 8'h3A;
        end else begin
            next_byte = body_byte(src_name, src_value, src_idx - 5'd3);
        end
`else
        next_byte = body_byte(src_name, src_value, src_idx);
`endif
    end

    // Next-state and next-output logic for the sweep / capture / send sequence.
    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path leaves it unassigned
        // (an unassigned path in always_comb would infer a latch).
        state_d    = state_q;
        number_d   = number_q;
        idx_d      = idx_q;
        name_d     = name_q;
        value_d    = value_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    number_d = FIRST_NUM;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (display_valid) begin
                    name_d     = display_name;
                    value_d    = display_value;
                    idx_d      = 5'd0;
                    tx_data_d  = next_byte;
                    tx_valid_d = 1'b1;
                    state_d    = S_SEND;
                end else if (number_q == LAST_NUM) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    number_d = number_q + 6'd1;
                    state_d  = S_WAIT;
                end
            end
            S_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        if (number_q == LAST_NUM) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            number_d = number_q + 6'd1;
                            state_d  = S_WAIT;
                        end
                    end else begin
                        idx_d     = idx_q + 5'd1;
                        tx_data_d = next_byte;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, line buffer and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the line buffer is only a few flops; clearing it on reset means an
            // aborted line leaves nothing stale behind.
            state_q    <= S_IDLE;
            number_q   <= 6'd0;
            idx_q      <= 5'd0;
            name_q     <= 40'd0;
            value_q    <= 32'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            state_q    <= state_d;
            number_q   <= number_d;
            idx_q      <= idx_d;
            name_q     <= name_d;
            value_q    <= value_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign display_number = number_q;
    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign scan_busy      = busy_q;
    assign scan_done      = done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: a registered responder model, a line-level
// reference model that predicts the byte stream, and a per-cycle monitor.
module tb_display_scanner;

    localparam int FIRST = 1;
    localparam int LAST  = 44;
`ifdef SCAN_INDEX_EN
    localparam int PFX = 3;
`else
    localparam int PFX = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        scan_start = 1'b0;
    logic [5:0]  display_number;
    logic        display_valid = 1'b0;
    logic [39:0] display_name = '0;
    logic [31:0] display_value = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        scan_busy;
    logic        scan_done;

    display_scanner dut (
        .clk            (clk),
        .resetn         (resetn),
        .scan_start     (scan_start),
        .display_number (display_number),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .scan_busy      (scan_busy),
        .scan_done      (scan_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Responder contents.
    bit          slot_valid [64];
    logic [39:0] slot_name  [64];
    logic [31:0] slot_value [64];

    logic [7:0] exp_q[$];
    logic [7:0] recv[$];
    int  n_xfer = 0;
    int  n_done = 0;
    int  cyc_cnt = 0;
    int  done_cyc = 0;
    int  start_cyc = 0;
    bit  sweep_active = 0;
    bit  rdy_random = 0;
    bit  prev_done = 0;
    bit  hold_pend = 0;
    logic [7:0] hold_data = 8'h00;
    logic [5:0] resp_num = 6'd0;

    always @(posedge clk) cyc_cnt++;

    // Responder with one register stage: answers for the number presented before the edge.
    always @(negedge clk) resp_num = display_number;
    always @(posedge clk) begin
        #1;
        display_valid = slot_valid[resp_num];
        display_name  = slot_name[resp_num];
        display_value = slot_value[resp_num];
    end

    always @(posedge clk) begin
        #1;
        if (rdy_random) tx_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic clear_table();
        for (int i = 0; i < 64; i++) begin
            slot_valid[i] = 0;
            slot_name[i]  = '0;
            slot_value[i] = '0;
        end
    endtask

    // Reference model: the text line a populated slot must produce.
    task automatic push_line(int num, logic [39:0] name, logic [31:0] value);
        string hexs = "0123456789ABCDEF";
        logic [7:0] c;
        logic [3:0] nib;
`ifdef SCAN_INDEX_EN
        exp_q.push_back(8'(48 + num / 10));
        exp_q.push_back(8'(48 + num % 10));
        exp_q.push_back(8'h3A);
`endif
        for (int i = 0; i < 5; i++) begin
            c = name[8*(4-i) +: 8];
            exp_q.push_back((c == 8'h00) ? 8'h20 : c);
        end
        exp_q.push_back(8'h3D);
        for (int i = 0; i < 8; i++) begin
            nib = value[4*(7-i) +: 4];
            exp_q.push_back(hexs[nib]);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int n = FIRST; n <= LAST; n++)
            if (slot_valid[n]) push_line(n, slot_name[n], slot_value[n]);
    endtask

    // Per-cycle monitor: stream order/content, hold while stalled, busy/done behaviour.
    always @(negedge clk) begin
        if (!resetn) begin
            hold_pend = 0;
            prev_done = 0;
        end else begin
            if (tx_valid) check("busy_while_tx", scan_busy, 1);
            if (hold_pend) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, hold_data);
            end
            hold_pend = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (tx_valid && tx_ready) begin
                check("tx_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
                recv.push_back(tx_data);
                n_xfer++;
            end
            if (scan_done) begin
                check("done_single", prev_done, 0);
                check("busy_at_done", scan_busy, 0);
                n_done++;
                done_cyc = cyc_cnt;
                sweep_active = 0;
            end else if (sweep_active) begin
                check("busy_in_sweep", scan_busy, 1);
            end
            prev_done = scan_done;
        end
    end

    task automatic start_sweep();
        build_expected();
        recv.delete();
        n_xfer = 0;
        n_done = 0;
        @(posedge clk); #1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        start_cyc = cyc_cnt;
        sweep_active = 1;
        check("start_number", display_number, FIRST);
        check("start_busy", scan_busy, 1);
    endtask

    task automatic wait_done(int budget);
        int c = 0;
        while (n_done == 0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("done_seen", n_done != 0, 1);
        repeat (3) @(posedge clk);
        #1;
        sweep_active = 0;
        check("stream_complete", exp_q.size(), 0);
        check("done_count", n_done, 1);
        check("idle_busy", scan_busy, 0);
    endtask

    task automatic wait_xfer(int target, int budget);
        int c = 0;
        while (n_xfer < target && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("xfer_reached", n_xfer >= target, 1);
    endtask

    function automatic string pfx(string s);
`ifdef SCAN_INDEX_EN
        return s;
`else
        return "";
`endif
    endfunction

    // Hand-written literal expectation for a whole received line.
    task automatic check_recv(string tag, string body);
        check({tag, "_len"}, recv.size(), body.len() + 2);
        for (int i = 0; i < body.len(); i++)
            if (i < recv.size()) check(tag, recv[i], body[i]);
        if (recv.size() == body.len() + 2) begin
            check({tag, "_cr"}, recv[body.len()], 8'h0D);
            check({tag, "_lf"}, recv[body.len() + 1], 8'h0A);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_table();
        repeat (3) @(posedge clk);
        #1;
        check("rst_number", display_number, 6'd0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", scan_busy, 0);
        check("rst_done", scan_done, 0);
        resetn = 1'b1;

        // Single populated slot, sink always ready.
        slot_valid[41] = 1;
        slot_name[41]  = 40'h4D_5F_4F_50_31;
        slot_value[41] = 32'h0000_002A;
        start_sweep();
        wait_done(3000);
        check_recv("t1_line", {pfx("41:"), "M_OP1=0000002A"});

        // No populated slot: done exactly 88 cycles after the start edge.
        clear_table();
        start_sweep();
        wait_done(3000);
        check("t2_latency", done_cyc - start_cyc, 88);
        check("t2_no_bytes", recv.size(), 0);

        // Sink stall of 10 cycles on the 7th byte of the body.
        clear_table();
        slot_valid[43] = 1;
        slot_name[43]  = 40'h50_52_4F_5F_48;
        slot_value[43] = 32'hDEAD_BEEF;
        fork
            begin
                start_sweep();
                wait_done(3000);
            end
            begin
                wait_xfer(6 + PFX, 2000);
                tx_ready = 1'b0;
                repeat (10) begin
                    check("t3_stall_valid", tx_valid, 1);
                    check("t3_stall_data", tx_data, 8'h44);
                    @(posedge clk); #1;
                end
                check("t3_no_xfer", n_xfer, 6 + PFX);
                tx_ready = 1'b1;
            end
        join
        check_recv("t3_line", {pfx("43:"), "PRO_H=DEADBEEF"});

        // NUL name chars, mid-line responder change, scan_start re-pulsed mid-sweep.
        clear_table();
        slot_valid[42] = 1;
        slot_name[42]  = 40'h00_00_00_41_42;
        slot_value[42] = 32'h0;
        rdy_random = 1;
        fork
            begin
                start_sweep();
                wait_done(3000);
            end
            begin
                wait_xfer(3, 2000);
                slot_name[42]  = 40'h5A_5A_5A_5A_5A;
                slot_value[42] = 32'h1;
                scan_start = 1'b1;
                @(posedge clk); #1;
                scan_start = 1'b0;
            end
        join
        rdy_random = 0;
        tx_ready = 1'b1;
        check_recv("t4_line", {pfx("42:"), "   AB=00000000"});
        check("t4_number_hold", display_number, LAST);

        // Reset while the 6th byte is pending, then a fresh sweep.
        clear_table();
        slot_valid[41] = 1;
        slot_name[41]  = 40'h4D_5F_4F_50_31;
        slot_value[41] = 32'h0000_002A;
        start_sweep();
        wait_xfer(5 + PFX, 2000);
        resetn = 1'b0;
        #1;
        check("t5_valid_drop", tx_valid, 0);
        check("t5_busy_drop", scan_busy, 0);
        check("t5_done_low", scan_done, 0);
        check("t5_number_rst", display_number, 6'd0);
        sweep_active = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        start_sweep();
        wait_done(3000);
        check_recv("t5_line", {pfx("41:"), "M_OP1=0000002A"});

        // Randomized tables and random sink backpressure.
        rdy_random = 1;
        for (int s = 0; s < 4; s++) begin
            for (int n = 0; n < 64; n++) begin
                slot_valid[n] = ($urandom_range(0, 3) == 0);
                for (int k = 0; k < 5; k++)
                    slot_name[n][8*k +: 8] = ($urandom_range(0, 4) == 0) ? 8'h00
                                             : 8'($urandom_range(33, 126));
                slot_value[n] = $urandom;
            end
            if (s == 0) begin
                slot_valid[FIRST] = 1;
                slot_valid[LAST]  = 1;
                slot_valid[LAST + 1] = 1;
                slot_valid[0] = 1;
            end
            start_sweep();
            wait_done(5000);
            check("rand_number_hold", display_number, LAST);
        end
        rdy_random = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
